// File: rtl/rx_clk_pkg.sv
// Shared types and widths for the rx DCM reset sequencer.
`timescale 1ns/1ps
package rx_clk_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset.
`timescale 1ns/1ps
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_dcm_ctrl.sv
// DCM reset sequencer and lock supervisor for the receive clock path.
// Runs on the buffered input clock so it keeps working while the DCM is unlocked.
//
//   state  | meaning
//   HOLD   | dcm_rst asserted for RST_CYCLES
//   WAIT   | DCM released, waiting for lock with timeout
//   STABLE | lock seen, must stay high for STABLE_CYCLES
//   RUN    | datapath released, lock monitored
//   FAIL   | retries exhausted, parked until restart/reset
`timescale 1ns/1ps
module rx_dcm_ctrl
    import rx_clk_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               rxclk,
    input  logic               reset,
    input  logic               locked,
    input  logic               restart,
    output logic               dcm_rst,
    output logic               rx_rst,
    output logic               ready,
    output logic               fail,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0]   RST_TC    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    rx_state_e        state;
    logic [CNT_W-1:0] count;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk   (rxclk),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    // Outputs are written together with the state transition so they always
    // reflect the state register without a decode delay.
    always_ff @(posedge rxclk) begin
        lock_lost <= 1'b0;
        if (reset || restart) begin
            state     <= ST_HOLD;
            count     <= '0;
            retry_cnt <= '0;
            dcm_rst   <= 1'b1;
            rx_rst    <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (count == RST_TC) begin
                        state   <= ST_WAIT;
                        count   <= '0;
                        dcm_rst <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (locked_s) begin
                        state <= ST_STABLE;
                        count <= '0;
                    end else if (count == LOCK_TC) begin
                        count <= '0;
                        if (retry_cnt == RETRY_MAX) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state     <= ST_HOLD;
                            retry_cnt <= retry_cnt + 1'b1;
                            dcm_rst   <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state <= ST_WAIT;
                        count <= '0;
                    end else if (count == STABLE_TC) begin
                        state  <= ST_RUN;
                        count  <= '0;
                        rx_rst <= 1'b0;
                        ready  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state     <= ST_HOLD;
                        count     <= '0;
                        retry_cnt <= '0;
                        lock_lost <= 1'b1;
                        dcm_rst   <= 1'b1;
                        rx_rst    <= 1'b1;
                        ready     <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state     <= ST_HOLD;
                    count     <= '0;
                    retry_cnt <= '0;
                    dcm_rst   <= 1'b1;
                    rx_rst    <= 1'b1;
                    ready     <= 1'b0;
                    fail      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_dcm_ctrl.sv
// Directed bench for rx_dcm_ctrl: vector table plus hand sequences for restart/reset.
`timescale 1ns/1ps
module tb_rx_dcm_ctrl;

    logic       rxclk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       dcm_rst, rx_rst, ready, fail, lock_lost;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    rx_dcm_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .rxclk     (rxclk),
        .reset     (reset),
        .locked    (locked),
        .restart   (restart),
        .dcm_rst   (dcm_rst),
        .rx_rst    (rx_rst),
        .ready     (ready),
        .fail      (fail),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    always #5 rxclk = ~rxclk;

    // exp = {dcm_rst, rx_rst, ready, fail, lock_lost, retry_cnt[3:0]}
    typedef struct {
        bit         rst_before;
        int         edge_n;
        bit         lock_after;
        logic [8:0] exp;
        string      name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input int e, input bit l,
                       input logic d, input logic rx, input logic rdy,
                       input logic f, input logic lost, input logic [3:0] rc,
                       input string nm);
        vec_t v;
        v.rst_before = r;
        v.edge_n     = e;
        v.lock_after = l;
        v.exp        = {d, rx, rdy, f, lost, rc};
        v.name       = nm;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge rxclk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        locked  = 1'b0;
        restart = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic check(input string nm, input logic [8:0] exp);
        logic [8:0] act;
        act = {dcm_rst, rx_rst, ready, fail, lock_lost, retry_cnt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got dcm/rx/rdy/fail/lost/retry=%b expected %b",
                     nm, edge_n, act, exp);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vq[i].rst_before) do_reset();
            while (edge_n < vq[i].edge_n) tick();
            check(vq[i].name, vq[i].exp);
            locked = vq[i].lock_after;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, c, d;

        // clean lock: locked first sampled at edge 10
        add(1,  1, 0, 1, 1, 0, 0, 0, 4'd0, "clean_e1");
        add(0,  3, 0, 1, 1, 0, 0, 0, 4'd0, "clean_hold_e3");
        add(0,  4, 0, 0, 1, 0, 0, 0, 4'd0, "clean_wait_e4");
        add(0,  9, 1, 0, 1, 0, 0, 0, 4'd0, "clean_e9");
        add(0, 19, 1, 0, 1, 0, 0, 0, 4'd0, "clean_stable_e19");
        add(0, 20, 1, 0, 0, 1, 0, 0, 4'd0, "clean_run_e20");
        // one timeout, then lock, then lock loss sampled at edge 45
        add(1, 23, 0, 0, 1, 0, 0, 0, 4'd0, "lost_wait_e23");
        add(0, 24, 0, 1, 1, 0, 0, 0, 4'd1, "lost_retry1_e24");
        add(0, 29, 1, 0, 1, 0, 0, 0, 4'd1, "lost_wait2_e29");
        add(0, 39, 1, 0, 1, 0, 0, 0, 4'd1, "lost_stable_e39");
        add(0, 40, 1, 0, 0, 1, 0, 0, 4'd1, "lost_run_e40");
        add(0, 44, 0, 0, 0, 1, 0, 0, 4'd1, "lost_run_e44");
        add(0, 46, 0, 0, 0, 1, 0, 0, 4'd1, "lost_run_e46");
        add(0, 47, 0, 1, 1, 0, 0, 1, 4'd0, "lost_pulse_e47");
        add(0, 48, 0, 1, 1, 0, 0, 0, 4'd0, "lost_pulse_end_e48");
        add(0, 50, 0, 1, 1, 0, 0, 0, 4'd0, "lost_hold_e50");
        add(0, 51, 0, 0, 1, 0, 0, 0, 4'd0, "lost_wait_e51");
        a = vq.size();
        // glitch: locked low for edges 15..17 while in STABLE
        add(1,  9, 1, 0, 1, 0, 0, 0, 4'd0, "glitch_e9");
        add(0, 14, 0, 0, 1, 0, 0, 0, 4'd0, "glitch_stable_e14");
        add(0, 17, 1, 0, 1, 0, 0, 0, 4'd0, "glitch_low_e17");
        add(0, 20, 1, 0, 1, 0, 0, 0, 4'd0, "glitch_norun_e20");
        add(0, 27, 1, 0, 1, 0, 0, 0, 4'd0, "glitch_stable_e27");
        add(0, 28, 1, 0, 0, 1, 0, 0, 4'd0, "glitch_run_e28");
        add(0, 29, 0, 0, 0, 1, 0, 0, 4'd0, "glitch_run_e29");
        b = vq.size();
        // never lock
        add(1, 47, 0, 0, 1, 0, 0, 0, 4'd1, "never_e47");
        add(0, 48, 0, 1, 1, 0, 0, 0, 4'd2, "never_retry2_e48");
        add(0, 52, 0, 0, 1, 0, 0, 0, 4'd2, "never_wait3_e52");
        add(0, 71, 0, 0, 1, 0, 0, 0, 4'd2, "never_e71");
        add(0, 72, 0, 0, 1, 0, 1, 0, 4'd2, "never_fail_e72");
        add(0, 90, 0, 0, 1, 0, 1, 0, 4'd2, "never_fail_hold_e90");
        c = vq.size();

        do_reset();
        check("reset_vals", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});

        run_range(0, a);

        run_range(a, b);
        // restart in RUN coinciding with lock loss (locked_s low at edge 32)
        while (edge_n < 31) tick();
        check("glitch_run_e31", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_run_e32", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        tick();
        check("restart_run_nolost_e33", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});

        run_range(b, c);
        // restart out of FAIL
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_fail_e91", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        while (edge_n < 94) tick();
        check("restart_fail_hold_e94", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        tick();
        check("restart_fail_wait_e95", {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});

        // reset mid-WAIT with retry_cnt=1
        do_reset();
        d = 30;
        while (edge_n < d) tick();
        check("midwait_e30", {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1});
        reset = 1'b1;
        tick();
        check("midwait_reset", {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_dcm_ctrl.md
# rx_dcm_ctrl

Reset sequencer and lock supervisor for the receive-path DCM clock generator. Drives the DCM reset with a guaranteed minimum pulse, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the receive datapath reset. Monitors lock during operation and automatically re-sequences on lock loss. Sits beside the rx clock generator and clocks from the buffered input clock, never from a DCM output.

## Interface
Parameters:
- RST_CYCLES, 8: cycles dcm_rst is held high per attempt (1..65536).
- LOCK_TIMEOUT, 4096: cycles to wait for lock per attempt (1..65536).
- STABLE_CYCLES, 64: cycles lock must stay continuously high before release (1..65536).
- MAX_RETRIES, 3: extra attempts after the first before declaring failure (0..15).

Ports:
- rxclk  in  1  buffered input clock (free-running, DCM-independent).
- reset  in  1  one clock; reset is synchronous and active-high.
- locked  in  1  DCM lock, asynchronous; synchronized internally.
- restart  in  1  single-cycle request to re-run the full sequence.
- dcm_rst  out  1  DCM reset.
- rx_rst  out  1  receive datapath reset; low only in RUN.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- lock_lost  out  1  one-cycle pulse on lock loss in RUN.
- retry_cnt  out  4  timeouts taken in the current sequence.

## Operation
- locked passes through a 2-flop synchronizer giving locked_s, so there are 2 cycles of added latency.
- States: HOLD, WAIT, STABLE, RUN, FAIL. A single 16-bit counter is cleared on every state entry.
- HOLD: dcm_rst=1. At count==RST_CYCLES-1, go to WAIT.
- WAIT: dcm_rst=0.
  - If locked_s=1, go to STABLE.
  - Else, at count==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - else retry_cnt++ and go to HOLD.
- STABLE: if locked_s=0, go to WAIT (timeout count restarts; retry_cnt unchanged). Else, at count==STABLE_CYCLES-1, go to RUN.
- RUN: rx_rst=0, ready=1. If locked_s=0: lock_lost=1 for one cycle, retry_cnt cleared, go to HOLD.
- FAIL: dcm_rst=0, fail=1. FAIL is terminal until restart or reset.
- restart=1 in any state: go to HOLD with counter and retry_cnt cleared. In RUN, restart takes precedence over lock loss, and lock_lost is not pulsed.
- Priority: reset > restart > lock/timeout conditions.
- All outputs are registered, decoded from the state register. lock_lost is a registered pulse.

## Timing
- Reset values: state HOLD, counter 0, retry_cnt 0, dcm_rst=1, rx_rst=1, ready=0, fail=0, lock_lost=0, synchronizer flops 0.
- Edge numbering: edge 1 is the first rising edge with reset sampled low.
- dcm_rst falls after edge RST_CYCLES. Reset mid-operation returns to HOLD on the next edge.
- Timed-out attempt period: RST_CYCLES+LOCK_TIMEOUT edges.
- FAIL is entered after edge (MAX_RETRIES+1)*(RST_CYCLES+LOCK_TIMEOUT), provided locked never rises.
- locked rising, first sampled at edge E while in WAIT:
  - STABLE after edge E+2;
  - RUN (rx_rst falls, ready rises) after edge E+2+STABLE_CYCLES.
- locked falling, sampled at edge E in RUN: after edge E+2, state HOLD, dcm_rst=1, rx_rst=1, and lock_lost high for exactly that one cycle.
- A locked glitch shorter than one cycle may be missed; this is acceptable.

## Structure
- Package rx_clk_pkg holds:
  - the state enum (HOLD, WAIT, STABLE, RUN, FAIL);
  - the counter width localparam (16);
  - the retry width localparam (4).
- One sub-module, sync_2ff: a generic 1-bit two-flop synchronizer with synchronous reset, used for locked.
- The FSM, counter and output registers live in rx_dcm_ctrl.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock: locked rises so it is first sampled at edge 10 → STABLE after edge 12, RUN after edge 20 with rx_rst=0 and ready=1. dcm_rst was high through edge 4, and retry_cnt=0.
- Never lock → retry_cnt goes 1 after edge 24 and 2 after edge 48. FAIL after edge 72 with fail=1, dcm_rst=0, rx_rst=1.
- Lock lost in RUN: locked drops, sampled at edge E → after edge E+2, lock_lost is a one-cycle pulse, dcm_rst=1, ready=0, and retry_cnt=0.
- Glitch in STABLE: locked low for 3 cycles mid-STABLE → return to WAIT, retry_cnt unchanged. RUN is reached only after 8 further contiguous locked_s cycles.
- Restart in FAIL and restart in RUN → HOLD on the next edge with retry_cnt=0. In RUN with simultaneous lock loss, lock_lost stays 0.
- reset asserted mid-WAIT with retry_cnt=1 → all outputs at reset values on the next edge.
